// File: rtl/wb_arb_pkg.sv
// Shared definitions for the write-back port arbiter: FSM encoding,
// register-address width and the default starvation limit.
package wb_arb_pkg;
  localparam int RA_W             = 5;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;
endpackage

// File: rtl/wb_arb_fifo.sv
// Multi-cycle result buffer with per-entry valid bits and squash-by-rd.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_arb_fifo import wb_arb_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [RA_W-1:0]          i_push_rd,
  input  logic [DATA_W-1:0]        i_push_data,
  input  logic                     i_pop,
  input  logic                     i_squash_en,
  input  logic [RA_W-1:0]          i_squash_rd,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_head_vld,
  output logic [RA_W-1:0]          o_head_rd,
  output logic [DATA_W-1:0]        o_head_data
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]    r_wr_ptr;
  logic [PTR_W:0]    r_rd_ptr;
  logic [DEPTH-1:0]  r_vld;
  logic [RA_W-1:0]   r_rd_mem   [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [PTR_W-1:0]  w_wr_idx;
  logic [PTR_W-1:0]  w_rd_idx;

  assign w_wr_idx = r_wr_ptr[PTR_W-1:0];
  assign w_rd_idx = r_rd_ptr[PTR_W-1:0];

  // A push whose rd matches the squash lands already invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_vld    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_squash_en && (r_rd_mem[i] == i_squash_rd)) r_vld[i] <= 1'b0;
      end
      if (i_push) begin
        r_vld[w_wr_idx] <= !(i_squash_en && (i_push_rd == i_squash_rd));
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_rd_mem[w_wr_idx]   <= i_push_rd;
      r_data_mem[w_wr_idx] <= i_push_data;
    end
  end

  assign o_empty     = (r_wr_ptr == r_rd_ptr);
  assign o_full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign o_level     = r_wr_ptr - r_rd_ptr;
  assign o_head_vld  = r_vld[w_rd_idx] && !o_empty;
  assign o_head_rd   = r_rd_mem[w_rd_idx];
  assign o_head_data = r_data_mem[w_rd_idx];
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the pipeline WB stage
// and buffered mult/div results. Define WB_ARB_STARVE_EN for forced drains.
module wb_port_arbiter import wb_arb_pkg::*; #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_reg_write,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              md_valid,
  input  logic [RA_W-1:0]   md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall_req
);
  localparam int PTR_W = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_port_arbiter: DEPTH must be a power of two >= 2");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("wb_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              w_full;
  logic              w_empty;
  logic [PTR_W:0]    w_level;
  logic [PTR_W:0]    w_level_nxt;
  logic              w_head_vld;
  logic [RA_W-1:0]   w_head_rd;
  logic [DATA_W-1:0] w_head_data;
  logic              w_push;
  logic              w_pop;
  logic              w_force;
  logic              w_pipe_gnt;
  logic              w_head_gnt;
  logic              w_next_empty;

  // rd=0 results are accepted but discarded so they never occupy the port.
  assign md_ready   = !w_full;
  assign w_push     = md_valid && md_ready && (md_rd != '0);
  assign w_pipe_gnt = rst_n && wb_reg_write && (wb_rd != '0) && !w_force;
  assign w_head_gnt = w_head_vld && !w_pipe_gnt;
  assign w_pop      = !w_empty && (!w_head_vld || w_head_gnt);

  assign w_level_nxt  = w_level + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
  assign w_next_empty = (w_level_nxt == '0);

  assign stall_req = w_force;
  assign rf_we     = w_pipe_gnt || w_head_gnt;
  assign rf_waddr  = w_pipe_gnt ? wb_rd   : (w_head_gnt ? w_head_rd   : '0);
  assign rf_wdata  = w_pipe_gnt ? wb_data : (w_head_gnt ? w_head_data : '0);

  wb_arb_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_rd   (md_rd),
    .i_push_data (md_data),
    .i_pop       (w_pop),
    .i_squash_en (w_pipe_gnt),
    .i_squash_rd (wb_rd),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (w_level),
    .o_head_vld  (w_head_vld),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

`ifdef WB_ARB_STARVE_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_cnt_nxt;

  assign w_force = (r_state == ST_FORCE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_starve_cnt <= '0;
    else        r_starve_cnt <= w_starve_cnt_nxt;
  end

  // The counter can never exceed LIMIT: reaching it moves the FSM to FORCE.
  always_comb begin
    w_state_nxt      = r_state;
    w_starve_cnt_nxt = r_starve_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_push) w_state_nxt = ST_PEND;
      end
      ST_PEND: begin
        if (w_head_gnt)      w_starve_cnt_nxt = '0;
        else if (w_head_vld) w_starve_cnt_nxt = r_starve_cnt + 4'd1;
        if (w_next_empty) begin
          w_state_nxt      = ST_IDLE;
          w_starve_cnt_nxt = '0;
        end else if (w_starve_cnt_nxt == LIMIT) begin
          w_state_nxt = ST_FORCE;
        end
      end
      ST_FORCE: begin
        w_starve_cnt_nxt = '0;
        w_state_nxt      = w_next_empty ? ST_IDLE : ST_PEND;
      end
      default: begin
        w_state_nxt      = ST_IDLE;
        w_starve_cnt_nxt = '0;
      end
    endcase
  end
`else
  assign w_force = 1'b0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_push)       w_state_nxt = ST_PEND;
      ST_PEND: if (w_next_empty) w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end
`endif
endmodule
